// File: rtl/archie_loader_pkg.sv
// ---------------------------------------------------------------------------
// archie_loader_pkg
// Shared types and constants for the RISC OS ROM loader (archie_rom_loader).
//   loader_entry_t : one queued Wishbone write {word address, byte lanes, data}
//   SEL_*          : byte-lane masks for low half, high half and full word
//   loader_state_e : Wishbone master FSM states
//   word_byte_addr : SDRAM byte address of a queued word
// ---------------------------------------------------------------------------
package archie_loader_pkg;

    typedef struct packed {
        logic [22:0] adr;   // ioctl_addr[24:2]
        logic [3:0]  sel;
        logic [31:0] dat;
    } loader_entry_t;

    localparam logic [3:0] SEL_LO  = 4'b0011;
    localparam logic [3:0] SEL_HI  = 4'b1100;
    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } loader_state_e;

    // Word address -> SDRAM byte address, wrapping at 26 bits.
    function automatic logic [25:0] word_byte_addr(input logic [25:0] base,
                                                   input logic [22:0] adr);
        return base + {1'b0, adr, 2'b00};
    endfunction

endpackage

// File: rtl/archie_loader_fifo.sv
// ---------------------------------------------------------------------------
// archie_loader_fifo
// Synchronous FIFO of loader_entry_t with show-ahead head output.
// Ports:
//   clk_sys, reset      : clock, synchronous active-high reset
//   push, push_data     : write request and entry (ignored when full)
//   pop                 : release the head entry (ignored when empty)
//   head                : current oldest entry (valid when !empty)
//   count, full, empty  : occupancy status
// DEPTH must be a power of two, minimum 2.
// ---------------------------------------------------------------------------
module archie_loader_fifo
    import archie_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  loader_entry_t            push_data,
    input  logic                     pop,
    output loader_entry_t            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    loader_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array is deliberately not reset; validity comes from
    // the pointers and count, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk_sys) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;  // idle, or push and pop together
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // The HPS is throttled by ioctl_wait well before the FIFO fills; a push
    // into a full FIFO means that handshake was broken and data is lost.
    push_into_full: assert property (@(posedge clk_sys) disable iff (reset)
                                     !(push && full));

endmodule

// File: rtl/archie_rom_loader.sv
// ---------------------------------------------------------------------------
// archie_rom_loader
// Packs the 16-bit hps_io download stream (RISC OS ROM, index 1) into 32-bit
// Wishbone classic write cycles toward the SDRAM mux, through a small FIFO,
// throttling the HPS with ioctl_wait.
// Ports:
//   clk_sys, reset           : clock, synchronous active-high reset
//   dl_active                : ioctl_download && index == 1
//   ioctl_wr/addr/dout       : halfword strobe, byte address, data
//   ioctl_wait               : HPS must hold off further ioctl_wr
//   wb_cyc/stb/we/sel/adr/dat_o, wb_ack : Wishbone master (write only)
//   busy                     : half pending, FIFO non-empty or cycle open
//   done                     : one-cycle pulse once a download has drained
//   checksum                 : (ARCHIE_LOADER_CHECKSUM_EN only) 32-bit sum of
//                              accepted halfwords, cleared at download start
// Optional feature macro: ARCHIE_LOADER_CHECKSUM_EN
// ---------------------------------------------------------------------------
module archie_rom_loader
    import archie_loader_pkg::*;
#(
    parameter logic [25:0] BASE_ADDR  = 26'h400000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [25:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack,
    output logic        busy,
    output logic        done
`ifdef ARCHIE_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam int             CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_GAP  = GAP;

    logic          dl_active_q;
    logic          dl_fell;
    logic          dl_rose;
    logic          wr_accept;

    loader_entry_t pend;
    logic          pend_valid;
    loader_entry_t new_half;
    logic          merge;
    logic          flush_hold;
    logic          flush_req;

    logic          push;
    logic          pop;
    loader_entry_t fifo_in;
    loader_entry_t fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    logic [1:0]    state;
    logic          in_req;
    logic          done_armed;
    logic          unused_addr_bit0;

    // Byte lane within a halfword is meaningless for a 16-bit stream.
    assign unused_addr_bit0 = ioctl_addr[0];

    assign dl_fell   = dl_active_q && !dl_active;
    assign dl_rose   = !dl_active_q && dl_active;
    assign wr_accept = ioctl_wr && dl_active;

    // Incoming halfword placed in its lane of a 32-bit word.
    always_comb begin
        new_half.adr = ioctl_addr[24:2];
        new_half.sel = ioctl_addr[1] ? SEL_HI : SEL_LO;
        new_half.dat = ioctl_addr[1] ? {ioctl_dout, 16'h0000}
                                     : {16'h0000, ioctl_dout};
    end

    // The pending entry only ever holds one half, so a differing sel at the
    // same word address is always the complementary half.
    assign merge = pend_valid && (pend.adr == new_half.adr)
                              && (pend.sel != new_half.sel);

    // A flush is owed while a half is pending after dl_active dropped; it is
    // held over if the FIFO is momentarily full.
    assign flush_req = pend_valid && (dl_fell || flush_hold);

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        push    = 1'b0;
        fifo_in = pend;
        if (flush_req) begin
            push = !fifo_full;
        end else if (wr_accept && pend_valid) begin
            push = 1'b1;
            if (merge)
                fifo_in = '{adr: pend.adr, sel: SEL_ALL,
                            dat: pend.dat | new_half.dat};
        end
    end

    assign pop = (state == ST_REQ) && wb_ack;

    archie_loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Packing register and download edge tracking.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            pend        <= '0;
            pend_valid  <= 1'b0;
            flush_hold  <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            if (flush_req) begin
                if (!fifo_full) begin
                    pend_valid <= 1'b0;
                    flush_hold <= 1'b0;
                end else begin
                    flush_hold <= 1'b1;
                end
            end else if (wr_accept) begin
                if (merge) begin
                    pend_valid <= 1'b0;
                end else begin
                    pend       <= new_half;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    // Wishbone master: one classic write per FIFO entry, with a one-cycle
    // gap after each ack so stb always drops between writes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (!fifo_empty) state <= ST_REQ;
                ST_REQ:  if (wb_ack)      state <= ST_GAP;
                ST_GAP:                   state <= ST_IDLE;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

    // done is armed by the falling edge and fires once everything drained.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            done_armed <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (dl_fell) begin
                done_armed <= 1'b1;
            end else if (dl_rose) begin
                done_armed <= 1'b0;
            end else if (done_armed && !pend_valid && fifo_empty
                         && (state == ST_IDLE)) begin
                done       <= 1'b1;
                done_armed <= 1'b0;
            end
        end
    end

`ifdef ARCHIE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_sys) begin
        if (reset)
            checksum <= '0;
        else if (dl_rose)
            checksum <= wr_accept ? {16'h0000, ioctl_dout} : 32'h0;
        else if (wr_accept)
            checksum <= checksum + {16'h0000, ioctl_dout};
    end
`endif

    assign in_req   = (state == ST_REQ);
    assign wb_cyc   = in_req;
    assign wb_stb   = in_req;
    assign wb_we    = in_req;
    assign wb_sel   = in_req ? fifo_head.sel : 4'h0;
    assign wb_adr   = in_req ? word_byte_addr(BASE_ADDR, fifo_head.adr) : 26'h0;
    assign wb_dat_o = in_req ? fifo_head.dat : 32'h0;

    assign busy       = pend_valid || !fifo_empty || (state != ST_IDLE);
    assign ioctl_wait = (fifo_count >= WAIT_LEVEL) || flush_req;

endmodule

// File: tb/tb_archie_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_archie_rom_loader
// Self-checking bench for archie_rom_loader: directed download vectors with
// hand-computed Wishbone writes, plus sequences for latency, back-pressure
// and reset during an open cycle. Define ARCHIE_LOADER_CHECKSUM_EN to also
// check the checksum output.
// ---------------------------------------------------------------------------
module tb_archie_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [25:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        busy;
    logic        done;
`ifdef ARCHIE_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk_sys = ~clk_sys;

    archie_rom_loader dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .dl_active  (dl_active),
        .ioctl_wr   (ioctl_wr),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .ioctl_wait (ioctl_wait),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_sel     (wb_sel),
        .wb_adr     (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_ack     (wb_ack),
        .busy       (busy),
`ifdef ARCHIE_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    typedef struct packed {
        logic [25:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        int          n_half;
        logic [24:0] a0;
        logic [15:0] d0;
        logic [24:0] a1;
        logic [15:0] d1;
        int          n_wr;
        wr_t         w0;
        wr_t         w1;
        logic [31:0] sum;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic ack_en = 1'b0;
    wr_t  wr_q[$];
    int   pairs_sent;
    int   blocked_at;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic wr_t get_wr(input int k);
        wr_t w;
        w = '0;
        if (k < wr_q.size())
            w = wr_q[k];
        return w;
    endfunction

    task automatic check_wr(input string tag, input int k, input wr_t exp);
        wr_t w;
        w = get_wr(k);
        check($sformatf("%s_w%0d_adr", tag, k), 32'(w.adr), 32'(exp.adr));
        check($sformatf("%s_w%0d_sel", tag, k), 32'(w.sel), 32'(exp.sel));
        check($sformatf("%s_w%0d_dat", tag, k), w.dat, exp.dat);
    endtask

    // Slave: acks any strobe seen at the falling edge and logs the write.
    initial begin
        wb_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (ack_en && wb_stb && !reset) begin
                wb_ack = 1'b1;
                wr_q.push_back('{adr: wb_adr, sel: wb_sel, dat: wb_dat_o});
            end else begin
                wb_ack = 1'b0;
            end
        end
    end

    // HPS side: honours ioctl_wait before every strobe.
    task automatic send_half(input logic [24:0] a, input logic [15:0] d);
        int n;
        n = 0;
        if (ioctl_wait && blocked_at < 0)
            blocked_at = pairs_sent;
        while (ioctl_wait && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        if (ioctl_wait)
            check("ioctl_wait_timeout", 32'(ioctl_wait), 32'd0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk_sys);
            if (done)
                seen = 1'b1;
        end
    endtask

    // Global bound: never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];

    initial begin
        logic seen;
        int   done_cnt;

        vecs[0] = '{2, 25'h0000000, 16'h1234, 25'h0000002, 16'hABCD, 1,
                    '{26'h0400000, 4'hF, 32'hABCD1234}, '0, 32'h0000BE01};
        vecs[1] = '{1, 25'h0000006, 16'h5555, 25'h0, 16'h0, 1,
                    '{26'h0400004, 4'hC, 32'h55550000}, '0, 32'h00005555};
        vecs[2] = '{2, 25'h0000000, 16'h1111, 25'h0000008, 16'h2222, 2,
                    '{26'h0400000, 4'h3, 32'h00001111},
                    '{26'h0400008, 4'h3, 32'h00002222}, 32'h00003333};
        vecs[3] = '{2, 25'h0000002, 16'hAAAA, 25'h0000002, 16'hBBBB, 2,
                    '{26'h0400000, 4'hC, 32'hAAAA0000},
                    '{26'h0400000, 4'hC, 32'hBBBB0000}, 32'h00016665};
        vecs[4] = '{2, 25'h000000E, 16'hCAFE, 25'h000000C, 16'hBEEF, 1,
                    '{26'h040000C, 4'hF, 32'hCAFEBEEF}, '0, 32'h000189ED};
        vecs[5] = '{2, 25'h1FFFFFC, 16'h0F0F, 25'h1FFFFFE, 16'hF0F0, 1,
                    '{26'h23FFFFC, 4'hF, 32'hF0F00F0F}, '0, 32'h0000FFFF};
        vecs[6] = '{2, 25'h0000011, 16'h7777, 25'h0000013, 16'h8888, 1,
                    '{26'h0400010, 4'hF, 32'h88887777}, '0, 32'h0000FFFF};
        vecs[7] = '{2, 25'h0000000, 16'hFFFF, 25'h0000002, 16'h0001, 1,
                    '{26'h0400000, 4'hF, 32'h0001FFFF}, '0, 32'h00010000};

        reset      = 1'b1;
        dl_active  = 1'b0;
        ioctl_wr   = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        pairs_sent = 0;
        blocked_at = -1;
        repeat (3) @(negedge clk_sys);

        // ---- reset state ----
        check("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        check("rst_wb_stb", 32'(wb_stb), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_sel", 32'(wb_sel), 32'd0);
        check("rst_wb_adr", 32'(wb_adr), 32'd0);
        check("rst_wb_dat", wb_dat_o, 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef ARCHIE_LOADER_CHECKSUM_EN
        check("rst_checksum", checksum, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk_sys);

        // ---- ioctl_wr while idle is ignored ----
        send_half(25'h0000000, 16'h9999);
        repeat (4) @(negedge clk_sys);
        check("idle_wr_busy", 32'(busy), 32'd0);
        check("idle_wr_stb", 32'(wb_stb), 32'd0);

        // ---- latency: push 1 cycle after the completing wr, stb 1 later ----
        dl_active = 1'b1;
        @(negedge clk_sys);
        send_half(25'h0000020, 16'h0001);
        send_half(25'h0000022, 16'h0002);
        check("lat_stb_early", 32'(wb_stb), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk_sys);
        check("lat_stb", 32'(wb_stb), 32'd1);
        check("lat_cyc", 32'(wb_cyc), 32'd1);
        check("lat_we", 32'(wb_we), 32'd1);
        check("lat_adr", 32'(wb_adr), 32'h0400020);
        check("lat_dat", wb_dat_o, 32'h00020001);
        ack_en = 1'b1;
        dl_active = 1'b0;
        wait_done(seen);
        check("lat_done", 32'(seen), 32'd1);
        check("lat_nwr", 32'(wr_q.size()), 32'd1);
        wr_q.delete();
        repeat (2) @(negedge clk_sys);

        // ---- table-driven downloads ----
        for (int i = 0; i < 8; i++) begin
            dl_active = 1'b1;
            @(negedge clk_sys);
            if (vecs[i].n_half >= 1)
                send_half(vecs[i].a0, vecs[i].d0);
            if (vecs[i].n_half >= 2)
                send_half(vecs[i].a1, vecs[i].d1);
            dl_active = 1'b0;
            wait_done(seen);
            check($sformatf("v%0d_done", i), 32'(seen), 32'd1);
`ifdef ARCHIE_LOADER_CHECKSUM_EN
            check($sformatf("v%0d_checksum", i), checksum, vecs[i].sum);
`endif
            @(negedge clk_sys);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_nwr", i), 32'(wr_q.size()), 32'(vecs[i].n_wr));
            check_wr($sformatf("v%0d", i), 0, vecs[i].w0);
            if (vecs[i].n_wr > 1)
                check_wr($sformatf("v%0d", i), 1, vecs[i].w1);
            wr_q.delete();
            @(negedge clk_sys);
        end

        // ---- back-pressure: ack withheld 50 cycles, 8 pairs streamed ----
        ack_en     = 1'b0;
        pairs_sent = 0;
        blocked_at = -1;
        dl_active  = 1'b1;
        @(negedge clk_sys);
        fork
            begin
                for (int p = 0; p < 8; p++) begin
                    send_half(25'h0000100 + 25'(4 * p), 16'h1000 + 16'(p));
                    send_half(25'h0000102 + 25'(4 * p), 16'h2000 + 16'(p));
                    pairs_sent = p + 1;
                end
            end
            begin
                repeat (50) @(negedge clk_sys);
                check("bp_wait_held", 32'(ioctl_wait), 32'd1);
                ack_en = 1'b1;
            end
        join
        dl_active = 1'b0;
        wait_done(seen);
        check("bp_done", 32'(seen), 32'd1);
        check("bp_blocked_at", 32'(blocked_at), 32'd3);
        check("bp_nwr", 32'(wr_q.size()), 32'd8);
        for (int p = 0; p < 8; p++)
            check_wr("bp", p, '{26'h0400100 + 26'(4 * p), 4'hF,
                                {16'h2000 + 16'(p), 16'h1000 + 16'(p)}});
        wr_q.delete();
        @(negedge clk_sys);

        // ---- reset while a cycle is open with 2 entries queued ----
        ack_en    = 1'b0;
        dl_active = 1'b1;
        @(negedge clk_sys);
        send_half(25'h0000040, 16'hAAAA);
        send_half(25'h0000042, 16'hBBBB);
        send_half(25'h0000044, 16'hCCCC);
        send_half(25'h0000046, 16'hDDDD);
        @(negedge clk_sys);
        check("rq_cyc_open", 32'(wb_cyc), 32'd1);
        reset     = 1'b1;
        dl_active = 1'b0;
        @(negedge clk_sys);
        check("rq_cyc_dropped", 32'(wb_cyc), 32'd0);
        check("rq_busy", 32'(busy), 32'd0);
        check("rq_wait", 32'(ioctl_wait), 32'd0);
        reset  = 1'b0;
        ack_en = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_sys);
            if (done)
                done_cnt++;
        end
        check("rq_no_writes", 32'(wr_q.size()), 32'd0);
        check("rq_no_done", 32'(done_cnt), 32'd0);
        check("rq_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
